// File: rtl/snake_vga_pkg.sv
// Shared types and constants for the snake VGA display path.
// Latency: n/a (declarations only).
// Backpressure: n/a. Holds the update FSM states, bus widths and snake_data field offsets.
package snake_vga_pkg;

    localparam int DATA_W  = 740;
    localparam int SCORE_W = 16;
    localparam int DIG_MAX = 99;

    // snake_data field offsets
    localparam int STAGE_MSB  = 359;
    localparam int STAGE_LSB  = 328;
    localparam int HEAD1_MSB  = 231;
    localparam int HEAD1_LSB  = 200;
    localparam int APPLE_MSB  = 455;
    localparam int APPLE_LSB  = 424;
    localparam int HEARTS_MSB = 487;
    localparam int HEARTS_LSB = 456;
    localparam int BODY_MSB   = 629;
    localparam int BODY_LSB   = 520;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_LOAD,
        ST_SHIFT,
        ST_COMMIT
    } fus_state_e;

    // BCD bits needed for a bin_w-bit value: ceil(bin_w * 1.2), rounded up to whole nibbles.
    function automatic int bcd_width(input int bin_w);
        int bits;
        bits = (bin_w * 6 + 4) / 5;
        return ((bits + 3) / 4) * 4;
    endfunction

endpackage

// File: rtl/frame_update_sequencer_if.sv
// Game-side / renderer-side bundle of the frame update sequencer.
// Latency: n/a (wiring only).
// Backpressure: none; iUpdReq is a level the game holds while its state is coherent.
// Ports: i* = live game state and update request, o* = committed render state and status.
interface frame_update_sequencer_if #(
    parameter int DATA_W  = snake_vga_pkg::DATA_W,
    parameter int SCORE_W = snake_vga_pkg::SCORE_W
);
    logic               iUpdReq;
    logic [DATA_W-1:0]  iSnakeData;
    logic [SCORE_W-1:0] iScore1;
    logic [SCORE_W-1:0] iScore2;
    logic [SCORE_W-1:0] iHighScore;

    logic               oUpdAck;
    logic [DATA_W-1:0]  oSnakeData;
    logic [31:0]        oStage;
    logic [3:0]         oDig1, oDig2, oDig3, oDig4, oDig5, oDig6;
    logic               oFrameTick;
    logic               oBusy;
    logic               oOverrun;

    modport master (
        output iUpdReq, iSnakeData, iScore1, iScore2, iHighScore,
        input  oUpdAck, oSnakeData, oStage, oDig1, oDig2, oDig3, oDig4, oDig5, oDig6,
               oFrameTick, oBusy, oOverrun
    );

    modport slave (
        input  iUpdReq, iSnakeData, iScore1, iScore2, iHighScore,
        output oUpdAck, oSnakeData, oStage, oDig1, oDig2, oDig3, oDig4, oDig5, oDig6,
               oFrameTick, oBusy, oOverrun
    );
endinterface

// File: rtl/frame_update_sequencer_bin2bcd_serial.sv
// Serial double-dabble binary-to-BCD engine shared by all three scores.
// Latency: 1 load cycle + SCORE_W shift cycles; result is presented combinationally on the last shift.
// Backpressure: none; the controller drives load/shift and watches done.
// Ports: load (restart with bin_dat), shift (one add-3/shift step), bcd_nxt (BCD after this step), done.
module bin2bcd_serial #(
    parameter int SCORE_W = 16,
    parameter int BCD_W   = 20
) (
    input  logic               iVGA_CLK,
    input  logic               iRST_n,
    input  logic               load,
    input  logic               shift,
    input  logic [SCORE_W-1:0] bin_dat,
    output logic [BCD_W-1:0]   bcd_nxt,
    output logic               done
);
    localparam int SR_W  = BCD_W + SCORE_W;
    localparam int CNT_W = $clog2(SCORE_W) + 1;

    // {bcd, remaining binary}; binary bits shift up into the BCD field one per step
    logic [SR_W-1:0]  sr_q, sr_d, adj, shifted;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        adj = sr_q;
        for (int i = 0; i < BCD_W / 4; i++) begin
            if (sr_q[SCORE_W + 4*i +: 4] >= 4'd5) begin
                adj[SCORE_W + 4*i +: 4] = sr_q[SCORE_W + 4*i +: 4] + 4'd3;
            end
        end
        shifted = adj << 1;

        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (load) begin
            sr_d  = {{BCD_W{1'b0}}, bin_dat};
            cnt_d = '0;
        end else if (shift) begin
            sr_d  = shifted;
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign bcd_nxt = shifted[SR_W-1:SCORE_W];
    assign done    = shift & (cnt_q == CNT_W'(SCORE_W - 1));

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/frame_update_sequencer.sv
// Vsync-synchronised snapshot of game state + serial score->BCD, committed atomically once per frame.
// Latency: vsync edge (E0) to commit (E53) is 53 clocks for SCORE_W=16; ack after E1, tick after E53.
// Backpressure: none; a vsync edge while busy is dropped and flagged on the sticky oOverrun.
// Ports: iVGA_CLK/iRST_n (async active-low), iVS (active-low vsync), bus (game inputs / render outputs).
module frame_update_sequencer #(
    parameter int SCORE_W = snake_vga_pkg::SCORE_W,
    parameter int DATA_W  = snake_vga_pkg::DATA_W,
    parameter int DIG_MAX = snake_vga_pkg::DIG_MAX
) (
    input  logic                    iVGA_CLK,
    input  logic                    iRST_n,
    input  logic                    iVS,
    frame_update_sequencer_if.slave bus
);
    import snake_vga_pkg::*;

    localparam int BCD_W = bcd_width(SCORE_W);

    fus_state_e                 state_q, state_d;
    logic                       vs_q, vs_d, vs_fall;
    logic [1:0]                 k_q, k_d;
    logic [DATA_W-1:0]          sh_data_q, sh_data_d;
    logic [DATA_W-1:0]          out_data_q, out_data_d;
    logic [2:0][SCORE_W-1:0]    sh_score_q, sh_score_d;
    logic [2:0][7:0]            pend_q, pend_d;   // {tens, ones} per score, not yet visible
    logic [2:0][7:0]            dig_q, dig_d;     // committed {tens, ones} per score
    logic                       ack_q, ack_d;
    logic                       tick_q, tick_d;
    logic                       busy_q, busy_d;
    logic                       ovr_q, ovr_d;

    logic                       eng_load, eng_shift, eng_done, sat;
    logic [BCD_W-1:0]           eng_bcd;
    logic [SCORE_W-1:0]         cur_score;

    assign vs_fall   = vs_q & ~iVS;
    assign cur_score = sh_score_q[k_q];
    // Two-digit display: anything above DIG_MAX (or any BCD nibble above tens) pins to 99
    assign sat       = (cur_score > SCORE_W'(DIG_MAX)) | (|eng_bcd[BCD_W-1:8]);

    bin2bcd_serial #(
        .SCORE_W (SCORE_W),
        .BCD_W   (BCD_W)
    ) u_bcd (
        .iVGA_CLK (iVGA_CLK),
        .iRST_n   (iRST_n),
        .load     (eng_load),
        .shift    (eng_shift),
        .bin_dat  (cur_score),
        .bcd_nxt  (eng_bcd),
        .done     (eng_done)
    );

    always_comb begin
        state_d    = state_q;
        vs_d       = iVS;
        k_d        = k_q;
        sh_data_d  = sh_data_q;
        sh_score_d = sh_score_q;
        pend_d     = pend_q;
        out_data_d = out_data_q;
        dig_d      = dig_q;
        ack_d      = 1'b0;
        tick_d     = 1'b0;
        eng_load   = 1'b0;
        eng_shift  = 1'b0;
        // a vsync edge mid-sequence is not queued, only reported
        ovr_d      = ovr_q | (vs_fall & (state_q != ST_IDLE));

        case (state_q)
            ST_IDLE: begin
                if (vs_fall && bus.iUpdReq) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                sh_data_d  = bus.iSnakeData;
                sh_score_d = {bus.iHighScore, bus.iScore2, bus.iScore1};
                ack_d      = 1'b1;
                k_d        = 2'd0;
                state_d    = ST_LOAD;
            end
            ST_LOAD: begin
                eng_load = 1'b1;
                state_d  = ST_SHIFT;
            end
            ST_SHIFT: begin
                eng_shift = 1'b1;
                if (eng_done) begin
                    pend_d[k_q] = sat ? 8'h99 : eng_bcd[7:0];
                    if (k_q < 2'd2) begin
                        k_d     = k_q + 2'd1;
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_COMMIT;
                    end
                end
            end
            ST_COMMIT: begin
                out_data_d = sh_data_q;
                dig_d      = pend_q;
                tick_d     = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q    <= ST_IDLE;
            vs_q       <= 1'b1;
            k_q        <= '0;
            sh_data_q  <= '0;
            sh_score_q <= '0;
            pend_q     <= '0;
            out_data_q <= '0;
            dig_q      <= '0;
            ack_q      <= 1'b0;
            tick_q     <= 1'b0;
            busy_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            vs_q       <= vs_d;
            k_q        <= k_d;
            sh_data_q  <= sh_data_d;
            sh_score_q <= sh_score_d;
            pend_q     <= pend_d;
            out_data_q <= out_data_d;
            dig_q      <= dig_d;
            ack_q      <= ack_d;
            tick_q     <= tick_d;
            busy_q     <= busy_d;
            ovr_q      <= ovr_d;
        end
    end

    assign bus.oUpdAck    = ack_q;
    assign bus.oSnakeData = out_data_q;
    assign bus.oStage     = out_data_q[STAGE_MSB:STAGE_LSB];
    assign bus.oDig1      = dig_q[0][7:4];
    assign bus.oDig2      = dig_q[0][3:0];
    assign bus.oDig3      = dig_q[1][7:4];
    assign bus.oDig4      = dig_q[1][3:0];
    assign bus.oDig5      = dig_q[2][7:4];
    assign bus.oDig6      = dig_q[2][3:0];
    assign bus.oFrameTick = tick_q;
    assign bus.oBusy      = busy_q;
    assign bus.oOverrun   = ovr_q;
endmodule

// File: tb/tb_frame_update_sequencer.sv
// Bench for frame_update_sequencer: directed frames plus random frames against a frame-level model.
// Latency: model commits 53 edges after the accepted vsync edge.
// Backpressure: n/a.
module tb_frame_update_sequencer;
    import snake_vga_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic vs;
    always #5 clk = ~clk;

    frame_update_sequencer_if bus ();

    frame_update_sequencer dut (
        .iVGA_CLK (clk),
        .iRST_n   (rst_n),
        .iVS      (vs),
        .bus      (bus)
    );

    int total = 0;
    int bad   = 0;
    int n_ack = 0, n_tick = 0, n_busy = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    logic               m_vs;
    int                 m_cnt;          // 0 = idle, else edges since the accepted vsync edge
    logic [DATA_W-1:0]  m_snap, e_data;
    logic [2:0][15:0]   m_sc;
    logic [2:0][7:0]    e_pair;
    logic               e_ack, e_tick, e_busy, e_ovr;

    function automatic logic [7:0] pair(input logic [15:0] s);
        int v;
        v = (s > 16'd99) ? 99 : int'(s);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_vs <= 1'b1; m_cnt <= 0; m_snap <= '0; m_sc <= '0; e_data <= '0; e_pair <= '0;
            e_ack <= 1'b0; e_tick <= 1'b0; e_busy <= 1'b0; e_ovr <= 1'b0;
        end else begin
            m_vs   <= vs;
            e_ack  <= (m_cnt == 1);
            e_tick <= (m_cnt == 53);
            if (m_cnt == 0) begin
                if (m_vs && !vs && bus.iUpdReq) begin
                    m_cnt  <= 1;
                    e_busy <= 1'b1;
                end
            end else begin
                if (m_vs && !vs) e_ovr <= 1'b1;
                if (m_cnt == 1) begin
                    m_snap <= bus.iSnakeData;
                    m_sc   <= {bus.iHighScore, bus.iScore2, bus.iScore1};
                end
                if (m_cnt == 53) begin
                    m_cnt  <= 0;
                    e_busy <= 1'b0;
                    e_data <= m_snap;
                    e_pair <= {pair(m_sc[2]), pair(m_sc[1]), pair(m_sc[0])};
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    function automatic logic [23:0] dut_digs();
        return {bus.oDig1, bus.oDig2, bus.oDig3, bus.oDig4, bus.oDig5, bus.oDig6};
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ack", 64'(bus.oUpdAck), 64'(e_ack));
            chk("tick", 64'(bus.oFrameTick), 64'(e_tick));
            chk("busy", 64'(bus.oBusy), 64'(e_busy));
            chk("overrun", 64'(bus.oOverrun), 64'(e_ovr));
            chk("digits", 64'(dut_digs()), 64'({e_pair[0], e_pair[1], e_pair[2]}));
            chk("stage", 64'(bus.oStage), 64'(e_data[STAGE_MSB:STAGE_LSB]));
            total++;
            if (bus.oSnakeData !== e_data) begin
                bad++;
                $display("FAIL snake_data: got %h want %h", bus.oSnakeData, e_data);
            end
            n_ack  += int'(bus.oUpdAck);
            n_tick += int'(bus.oFrameTick);
            n_busy += int'(bus.oBusy);
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [15:0] rscore();
        if ($urandom_range(0, 3) == 0) return 16'($urandom);
        return 16'($urandom_range(0, 110));
    endfunction

    task automatic set_in(input bit req, input logic [15:0] s1, input logic [15:0] s2,
                          input logic [15:0] hs, input logic [31:0] stage);
        logic [767:0] tmp;
        for (int i = 0; i < 24; i++) tmp[32*i +: 32] = $urandom;
        tmp[STAGE_MSB:STAGE_LSB] = stage;
        bus.iSnakeData = tmp[DATA_W-1:0];
        bus.iUpdReq    = req;
        bus.iScore1    = s1;
        bus.iScore2    = s2;
        bus.iHighScore = hs;
    endtask

    // Drops vsync so the next edge is E0, then runs 57 edges with optional events at given edges.
    task automatic frame(input int ovr_at, input int chg_at, input logic [31:0] chg_stage,
                         input bit chg_rand, input int rst_at);
        vs = 1'b0;
        for (int e = 0; e <= 56; e++) begin
            @(posedge clk); #1;
            if (e == 0) vs = 1'b1;
            if (ovr_at > 0 && e == ovr_at - 1) vs = 1'b0;
            if (ovr_at > 0 && e == ovr_at) vs = 1'b1;
            if (chg_at > 0 && e == chg_at) begin
                if (chg_rand) set_in(1'($urandom), rscore(), rscore(), rscore(), chg_stage);
                else bus.iSnakeData[STAGE_MSB:STAGE_LSB] = chg_stage;
            end
            if (rst_at > 0 && e == rst_at - 1) rst_n = 1'b0;
            if (rst_at > 0 && e == rst_at + 1) rst_n = 1'b1;
        end
    endtask

    int a0, t0, b0;

    initial begin
        rst_n = 1'b0;
        vs    = 1'b1;
        set_in(1'b0, 16'd0, 16'd0, 16'd0, 32'd0);
        @(posedge clk); #1;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset_busy", 64'(bus.oBusy), 64'd0);
        chk("reset_digits", 64'(dut_digs()), 64'd0);

        // basic frame; stage changes at E5 must not leak into this commit
        a0 = n_ack; t0 = n_tick;
        set_in(1'b1, 16'd42, 16'd7, 16'd99, 32'd2);
        frame(-1, 5, 32'd3, 1'b0, -1);
        chk("f1_digits", 64'(dut_digs()), 64'h420799);
        chk("f1_stage", 64'(bus.oStage), 64'd2);
        chk("f1_acks", 64'(n_ack - a0), 64'd1);
        chk("f1_ticks", 64'(n_tick - t0), 64'd1);

        // saturation; stage 3 from the previous change now commits
        set_in(1'b1, 16'd100, 16'd65535, 16'd0, 32'd3);
        frame(-1, -1, 32'd0, 1'b0, -1);
        chk("sat_digits", 64'(dut_digs()), 64'h999900);
        chk("sat_stage", 64'(bus.oStage), 64'd3);

        // skipped frame
        a0 = n_ack; t0 = n_tick; b0 = n_busy;
        set_in(1'b0, 16'd5, 16'd5, 16'd5, 32'd4);
        frame(-1, -1, 32'd0, 1'b0, -1);
        chk("skip_digits", 64'(dut_digs()), 64'h999900);
        chk("skip_stage", 64'(bus.oStage), 64'd3);
        chk("skip_acks", 64'(n_ack - a0), 64'd0);
        chk("skip_ticks", 64'(n_tick - t0), 64'd0);
        chk("skip_busy", 64'(n_busy - b0), 64'd0);

        // second vsync at E20 plus input churn after E1
        set_in(1'b1, 16'd13, 16'd58, 16'd77, 32'd6);
        frame(20, 25, 32'd9, 1'b1, -1);
        chk("ovr_flag", 64'(bus.oOverrun), 64'd1);
        chk("ovr_digits", 64'(dut_digs()), 64'h135877);
        chk("ovr_stage", 64'(bus.oStage), 64'd6);

        // reset mid-sequence at E30
        t0 = n_tick;
        set_in(1'b1, 16'd50, 16'd50, 16'd50, 32'd7);
        frame(-1, -1, 32'd0, 1'b0, 30);
        chk("rst_digits", 64'(dut_digs()), 64'd0);
        chk("rst_stage", 64'(bus.oStage), 64'd0);
        chk("rst_ovr", 64'(bus.oOverrun), 64'd0);
        chk("rst_ticks", 64'(n_tick - t0), 64'd0);

        // normal frame after reset
        t0 = n_tick;
        set_in(1'b1, 16'd21, 16'd0, 16'd5, 32'd8);
        frame(-1, -1, 32'd0, 1'b0, -1);
        chk("post_digits", 64'(dut_digs()), 64'h210005);
        chk("post_stage", 64'(bus.oStage), 64'd8);
        chk("post_ticks", 64'(n_tick - t0), 64'd1);

        // random frames
        for (int it = 0; it < 30; it++) begin
            int ovr_at, chg_at, rst_at;
            ovr_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(3, 54)) : -1;
            chg_at = int'($urandom_range(2, 50));
            rst_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(3, 55)) : -1;
            set_in($urandom_range(0, 4) != 0, rscore(), rscore(), rscore(), $urandom);
            frame(ovr_at, chg_at, $urandom, 1'b1, rst_at);
            repeat ($urandom_range(0, 4)) @(posedge clk);
            #1;
        end

        repeat (2) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/frame_update_sequencer.md
# frame_update_sequencer

Vsync-synchronised update controller sitting between the game-logic side and `vga_controller`. Once per frame, at the start of the vertical sync pulse, it:
- snapshots the packed 740-bit snake state bus;
- serially converts three binary scores into six display digits through one shared binary-to-BCD engine;
- commits all rendered state atomically, so the pixel datapath never sees a half-updated frame.

It replaces the static digit registers and the live `snake_data` connection feeding the renderer.

## Interface
Parameters:
- `SCORE_W`, 16, width of each binary score input.
- `DATA_W`, 740, width of the packed snake state bus.
- `DIG_MAX`, 99, saturation value of the two-digit display per score.

Ports:
- `iVGA_CLK` in 1: pixel clock; all logic is on the rising edge.
- `iRST_n` in 1: reset, asynchronous, active-low.
- `iVS` in 1: active-low vsync from `video_sync_generator`, synchronous to `iVGA_CLK`.
- `iUpdReq` in 1: game side holds this high while `iSnakeData` and the scores are coherent.
- `iSnakeData` in `DATA_W`: live packed game state.
- `iScore1`, `iScore2`, `iHighScore` in `SCORE_W` each: binary scores.
- `oUpdAck` out 1: one-cycle pulse when the snapshot is taken.
- `oSnakeData` out `DATA_W`: committed snapshot.
- `oStage` out 32: committed `oSnakeData[359:328]`.
- `oDig1`..`oDig6` out 4 each: committed BCD digits. Pairs are tens/ones of `iScore1`, `iScore2` and `iHighScore`.
- `oFrameTick` out 1: one-cycle pulse on commit.
- `oBusy` out 1: high in every state except IDLE.
- `oOverrun` out 1: sticky; set when a vsync edge arrives while busy.

## Operation
- Vsync edge detect: `vs_q` is a registered copy of `iVS`, reset to 1. The event `vs_fall = vs_q & ~iVS`.
- FSM states: IDLE, CAPTURE, LOAD, SHIFT, COMMIT.
  - IDLE: on `vs_fall` with `iUpdReq`=1, go to CAPTURE. On `vs_fall` with `iUpdReq`=0, stay in IDLE; the frame is skipped, outputs hold, and no tick is issued.
  - CAPTURE: latch `iSnakeData` and all three scores into shadow registers; pulse `oUpdAck`; set score index k=0; go to LOAD.
  - LOAD: load shadow score k into the BCD engine; go to SHIFT.
  - SHIFT: `SCORE_W` double-dabble cycles (add-3 on any nibble ≥5, then shift left 1). After the last shift:
    - store the tens/ones of score k into the pending digit registers;
    - if k<2: k++ and go to LOAD;
    - otherwise go to COMMIT.
  - COMMIT: copy the shadow data and pending digits to the outputs; pulse `oFrameTick`; go to IDLE.
- Arithmetic: the engine holds ceil(`SCORE_W`·1.2) BCD bits (5 nibbles for 16). If the score exceeds `DIG_MAX`, or any nibble above tens is nonzero, the pair is 9,9.
- Overrun: `vs_fall` in any non-IDLE state sets `oOverrun`. The sequence in progress continues unchanged, and the edge is not queued.
- `iUpdReq` is sampled only at `vs_fall` in IDLE. Dropping it mid-sequence has no effect.
- Reset values, applied asynchronously at any time including mid-sequence:
  - state IDLE, `vs_q`=1;
  - all data outputs 0, `oDig*`=0;
  - `oUpdAck`, `oFrameTick`, `oBusy`, `oOverrun` = 0;
  - pending and shadow registers are cleared, so no partial commit ever reaches the outputs.

## Timing
- E0 is the clock edge on which `vs_fall` and `iUpdReq` are sampled true in IDLE.
- `oBusy` rises after E0. `oUpdAck` is high for exactly the cycle after E1.
- Snapshot data is taken at E1. Input changes after E1 do not affect this frame.
- Each score takes 1 LOAD + `SCORE_W` SHIFT edges, i.e. 17 edges.
- All outputs change together at E53 (`SCORE_W`=16). `oFrameTick` is high for the cycle following E53, and `oBusy` falls in that same cycle.
- Worst-case latency is 53 clocks, well inside the 2-line vsync pulse (1600 clocks), so commit always lands before active video.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package `snake_vga_pkg` holds:
  - the FSM state enum;
  - `DATA_W`, `SCORE_W` and `DIG_MAX`;
  - `snake_data` field offsets: stage 359:328, head1pos 231:200, apple 455:424, hearts 487:456, body 629:520.
- One sub-module, `bin2bcd_serial`, is the load/shift engine with a done flag. The FSM, shadow registers and commit logic stay in the top.

## Test plan
- Reset release, then `iVS` falls with `iUpdReq`=1, `iScore1`=42, `iScore2`=7, `iHighScore`=99 → `oUpdAck` after E1; at E53 digits become 4,2,0,7,9,9; one `oFrameTick`.
- Score saturation: `iScore1`=100, `iScore2`=65535, `iHighScore`=0 → digits 9,9,9,9,0,0.
- Change `iSnakeData[359:328]` from 2 to 3 at E5 → `oStage` commits 2 at E53, and 3 only after the next frame.
- `iUpdReq`=0 at vsync edge → no ack, no tick, `oBusy` stays 0, outputs unchanged.
- Second vsync edge forced at E20 → `oOverrun`=1 and stays 1; commit still occurs at E53 with the E1 data.
- Assert `iRST_n`=0 at E30, then release → all outputs 0, no tick. The next vsync runs a full 53-cycle sequence normally.
